// File: rtl/y_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : y_div_seq
// Purpose  : Sequential unsigned restoring divider that borrows an external
//            ALU. Each cycle it issues one compare (signed SLT on MSB-flipped
//            operands, which gives an unsigned compare) or one subtract, and
//            consumes the ALU result and zero flag. Valid/ready handshakes on
//            both the request and the response side.
// Build    : define Y_DIV_ZERO_CHECK_EN to add the ZCHK state, which resolves
//            a zero divisor in one cycle and raises div_by_zero. Without it a
//            zero divisor runs the full loop (Q = all ones, R = dividend) and
//            div_by_zero is tied low.
// Ports    : clk, resetn (async, active-low)
//            start_valid/start_ready, dividend, divisor  : request
//            res_valid/res_ready, quotient, remainder,
//            div_by_zero                                  : response
//            alu_a, alu_b, alu_op (out), alu_z, alu_ex (in): shared ALU
// Revision : 1.0 - initial release
// ============================================================================
module y_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_z,
  input  logic             alu_ex
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [CW-1:0]    c_cnt_last = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] c_msb      = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2:0]       c_op_and   = 3'b000;
  localparam logic [2:0]       c_op_add   = 3'b010;
  localparam logic [2:0]       c_op_sub   = 3'b110;
  localparam logic [2:0]       c_op_slt   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
`ifdef Y_DIV_ZERO_CHECK_EN
    S_ZCHK = 3'd1,
`endif
    S_CMP  = 3'd2,
    S_SUB  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dsr;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;

  // Partial remainder shifted left with the next dividend bit. The previous
  // partial remainder is always below 2^(W-1), so nothing is lost off the top.
  logic [WIDTH-1:0] w_shift;
  logic             w_last;

  assign w_shift = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
  assign w_last  = (r_cnt == c_cnt_last);

  assign start_ready = (r_state == S_IDLE);
  assign res_valid   = (r_state == S_DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and ALU drive
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    alu_a       = '0;
    alu_b       = '0;
    alu_op      = c_op_and;
    case (r_state)
      S_IDLE: begin
        if (start_valid) begin
`ifdef Y_DIV_ZERO_CHECK_EN
          w_state_nxt = S_ZCHK;
`else
          w_state_nxt = S_CMP;
`endif
        end
      end
`ifdef Y_DIV_ZERO_CHECK_EN
      S_ZCHK: begin
        // divisor + 0 lets the ALU zero flag report a zero divisor
        alu_a       = r_dsr;
        alu_op      = c_op_add;
        w_state_nxt = alu_ex ? S_DONE : S_CMP;
      end
`endif
      S_CMP: begin
        // flipping both MSBs maps unsigned order onto signed order
        alu_a  = w_shift ^ c_msb;
        alu_b  = r_dsr ^ c_msb;
        alu_op = c_op_slt;
        if (!alu_z[0]) begin
          w_state_nxt = S_SUB;
        end else if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_CMP;
        end
      end
      S_SUB: begin
        alu_a       = r_rem;
        alu_b       = r_dsr;
        alu_op      = c_op_sub;
        w_state_nxt = w_last ? S_DONE : S_CMP;
      end
      S_DONE: begin
        if (res_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and result registers
  // --------------------------------------------------------------------------
`ifdef Y_DIV_ZERO_CHECK_EN
  logic r_dbz;
  assign div_by_zero = r_dbz;
`else
  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rem       <= '0;
      r_quo       <= '0;
      r_dsr       <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
`ifdef Y_DIV_ZERO_CHECK_EN
      r_dbz       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_valid) begin
            r_rem <= '0;
            r_quo <= dividend;
            r_dsr <= divisor;
            r_cnt <= '0;
          end
        end
`ifdef Y_DIV_ZERO_CHECK_EN
        S_ZCHK: begin
          if (alu_ex) begin
            // r_quo still holds the unshifted dividend here
            r_quotient  <= '1;
            r_remainder <= r_quo;
            r_dbz       <= 1'b1;
          end
        end
`endif
        S_CMP: begin
          r_rem <= w_shift;
          r_quo <= {r_quo[WIDTH-2:0], 1'b0};
          if (alu_z[0]) begin
            if (w_last) begin
              r_quotient  <= {r_quo[WIDTH-2:0], 1'b0};
              r_remainder <= w_shift;
`ifdef Y_DIV_ZERO_CHECK_EN
              r_dbz       <= 1'b0;
`endif
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_SUB: begin
          r_rem    <= alu_z;
          r_quo[0] <= 1'b1;
          if (w_last) begin
            r_quotient  <= {r_quo[WIDTH-1:1], 1'b1};
            r_remainder <= alu_z;
`ifdef Y_DIV_ZERO_CHECK_EN
            r_dbz       <= 1'b0;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_y_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_y_div_seq
// Purpose  : Directed self-checking bench for y_div_seq with a behavioural
//            ALU model (AND/OR/ADD/SUB/signed SLT, zero flag).
// Revision : 1.0 - initial release
// ============================================================================
module tb_y_div_seq;

`ifdef Y_DIV_ZERO_CHECK_EN
  localparam int ZX = 1;
`else
  localparam int ZX = 0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_z;
  logic        alu_ex;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  y_div_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_z       (alu_z),
    .alu_ex      (alu_ex)
  );

  // External ALU model
  always_comb begin
    alu_z = '0;
    case (alu_op)
      3'b000: alu_z = alu_a & alu_b;
      3'b001: alu_z = alu_a | alu_b;
      3'b010: alu_z = alu_a + alu_b;
      3'b110: alu_z = alu_a - alu_b;
      3'b111: alu_z = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_z = '0;
    endcase
  end
  assign alu_ex = (alu_z == 32'd0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " start_ready"}, {31'd0, start_ready}, 32'd1);
    check({tag, " res_valid"},   {31'd0, res_valid},   32'd0);
    check({tag, " quotient"},    quotient,             32'd0);
    check({tag, " remainder"},   remainder,            32'd0);
    check({tag, " div_by_zero"}, {31'd0, div_by_zero}, 32'd0);
    check({tag, " alu_a"},       alu_a,                32'd0);
    check({tag, " alu_b"},       alu_b,                32'd0);
    check({tag, " alu_op"},      {29'd0, alu_op},      32'd0);
  endtask

  // Presents a request just after an edge; the following edge accepts it.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    check("ready before issue", {31'd0, start_ready}, 32'd1);
    start_valid = 1'b1;
    dividend    = a;
    divisor     = b;
    @(posedge clk); #1;
    start_valid = 1'b0;
  endtask

  // Called 1 time unit after the accepting edge; counts edges until res_valid.
  task automatic collect(input string tag, input logic [31:0] eq, input logic [31:0] er,
                         input logic edz, input int elat);
    int lat = 0;
    while (!res_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"},     lat,                  elat);
    check({tag, " quotient"},    quotient,             eq);
    check({tag, " remainder"},   remainder,            er);
    check({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, edz});
    check({tag, " start_ready"}, {31'd0, start_ready}, 32'd0);
  endtask

  task automatic ack(input string tag);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check({tag, " ack res_valid"},   {31'd0, res_valid},   32'd0);
    check({tag, " ack start_ready"}, {31'd0, start_ready}, 32'd1);
  endtask

  initial begin
    // Reset state
    #2;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("idle");

    // 100 / 7 -> 14 r 2, popcount(14)=3
    issue(32'd100, 32'd7);
    collect("100/7", 32'd14, 32'd2, 1'b0, 35 + ZX);
    ack("100/7");

    // Maximum-length path: every iteration subtracts
    issue(32'hFFFF_FFFF, 32'd1);
    collect("max/1", 32'hFFFF_FFFF, 32'd0, 1'b0, 64 + ZX);
    ack("max/1");

    // Final shifted remainder has bit 31 set: needs the unsigned compare
    issue(32'hFFFF_FFFF, 32'h8000_0001);
    collect("msb", 32'd1, 32'h7FFF_FFFE, 1'b0, 33 + ZX);
    ack("msb");

    // Divide by zero
    issue(32'd1234, 32'd0);
`ifdef Y_DIV_ZERO_CHECK_EN
    check("zchk alu_op", {29'd0, alu_op}, 32'd2);
    check("zchk alu_a",  alu_a, 32'd0);
    check("zchk alu_b",  alu_b, 32'd0);
    collect("div0", 32'hFFFF_FFFF, 32'd1234, 1'b1, 1);
`else
    check("cmp alu_op", {29'd0, alu_op}, 32'd7);
    check("cmp alu_a",  alu_a, 32'h8000_0000);
    check("cmp alu_b",  alu_b, 32'h8000_0000);
    collect("div0", 32'hFFFF_FFFF, 32'd1234, 1'b0, 64);
`endif
    check("done alu_op", {29'd0, alu_op}, 32'd0);
    ack("div0");

    // Response back-pressure with a competing request held valid
    issue(32'd50, 32'd5);
    collect("50/5", 32'd10, 32'd0, 1'b0, 34 + ZX);
    start_valid = 1'b1;
    dividend    = 32'd9;
    divisor     = 32'd3;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold res_valid",   {31'd0, res_valid},   32'd1);
      check("hold start_ready", {31'd0, start_ready}, 32'd0);
      check("hold quotient",    quotient,             32'd10);
      check("hold remainder",   remainder,            32'd0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("handshake res_valid",   {31'd0, res_valid},   32'd0);
    check("handshake start_ready", {31'd0, start_ready}, 32'd1);
    @(posedge clk); #1;
    start_valid = 1'b0;
    collect("9/3 queued", 32'd3, 32'd0, 1'b0, 34 + ZX);
    ack("9/3 queued");

    // Asynchronous reset in the middle of an operation
    issue(32'hFFFF_0000, 32'd3);
    repeat (9) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    issue(32'd9, 32'd3);
    collect("9/3 after reset", 32'd3, 32'd0, 1'b0, 34 + ZX);
    ack("9/3 after reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/y_div_seq.md
# y_div_seq

Sequential 32-bit unsigned restoring divider that acts as the initiator on the ALU operand/op interface. It issues one compare (slt) or subtract operation per cycle to an external ALU and consumes its result and zero flag. A valid/ready request and response handshake connects it to the datapath controller, so a single ALU is shared between normal execution and divide operations.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; must equal the ALU width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start_valid`  in  1  request valid.
- `start_ready`  out  1  high only in IDLE.
- `dividend`  in  WIDTH  sampled on request accept.
- `divisor`  in  WIDTH  sampled on request accept.
- `res_valid`  out  1  result valid, held until accepted.
- `res_ready`  in  1  result accept.
- `quotient`  out  WIDTH  registered result.
- `remainder`  out  WIDTH  registered result.
- `div_by_zero`  out  1  registered; meaningful only when `res_valid`=1.
- `alu_a`, `alu_b`  out  WIDTH  ALU operands.
- `alu_op`  out  3  ALU op: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 signed SLT.
- `alu_z`  in  WIDTH  ALU result, combinational from `alu_*`.
- `alu_ex`  in  1  ALU zero flag (`alu_z`==0).

## Operation
- States are IDLE, ZCHK, CMP, SUB and DONE. Registers are `rem`, `quo`, `dsr` and a 5-bit `cnt`.
- **IDLE**
  - On `start_valid & start_ready`: `rem`<=0, `quo`<=dividend, `dsr`<=divisor, `cnt`<=0.
  - Next state is ZCHK, or CMP if the macro is undefined.
- **ZCHK**
  - Drives `alu_a`=`dsr`, `alu_b`=0, `alu_op`=010.
  - If `alu_ex`=1: `quotient`<=all ones, `remainder`<=dividend, `div_by_zero`<=1, and go to DONE.
  - Otherwise go to CMP.
- **CMP**
  - R' = {`rem`[W-2:0], `quo`[W-1]}.
  - Drives `alu_a`=R'^MSB, `alu_b`=`dsr`^MSB, `alu_op`=111. MSB means bit W-1 set; the MSB flip turns signed SLT into an unsigned compare.
  - Updates `rem`<=R' and `quo`<=`quo`<<1.
  - If `alu_z`[0]=0 (R'>=`dsr`), go to SUB.
  - Else if `cnt`=W-1, go to DONE.
  - Else `cnt`++ and go to CMP.
- **SUB**
  - Drives `alu_a`=`rem`, `alu_b`=`dsr`, `alu_op`=110.
  - Updates `rem`<=`alu_z` and `quo`[0]<=1.
  - Then go to DONE if `cnt`=W-1; else `cnt`++ and go to CMP.
- **Entering DONE from the iteration:** `quotient`<=final `quo`, `remainder`<=final `rem`, `div_by_zero`<=0.
- **DONE**
  - `res_valid`=1; outputs stay stable.
  - On `res_ready`, go to IDLE.
  - `start_valid` is ignored.
- ALU outputs are 0 with `alu_op`=000 in IDLE and DONE.
- Remainder R' never exceeds 2^W-1, because the partial remainder is always below 2^(W-1) before the shift. No carry bit is kept.

## Timing
- **Reset values:** `start_ready`=1, `res_valid`=0, `quotient`=`remainder`=0, `div_by_zero`=0, `alu_a`=`alu_b`=0, `alu_op`=000, state IDLE.
- **Reset mid-operation:** the in-flight operation is lost; state returns to IDLE immediately.
- **Result latency** (accepting edge to the edge that raises `res_valid`):
  - With the macro: 1 + W + popcount(Q).
  - With the macro and divisor = 0: exactly 1.
  - Without the macro: W + popcount(Q).
- **Maximum latency:** 65 cycles with the macro, 64 without.
- **Back-to-back requests:** the earliest next accept is one cycle after the `res_ready` handshake, since `start_ready` is asserted only in IDLE.
- **Handshake:** `start_ready` is a function of state only. No combinational path exists from `start_valid` or `res_ready` to any output.

## Configuration
- `Y_DIV_ZERO_CHECK_EN` defined:
  - The ZCHK state exists.
  - Divide-by-zero short-circuits with `div_by_zero`=1 in 1 cycle.
- Undefined:
  - ZCHK is removed and `div_by_zero` is tied to 0.
  - Divisor 0 runs the full loop and naturally yields Q=all ones, R=dividend in 64 cycles.

## Test plan
- 100 / 7 -> Q=14, R=2, `div_by_zero`=0, `res_valid` 36 edges after accept (35 without the macro).
- 0xFFFFFFFF / 1 -> Q=0xFFFFFFFF, R=0, latency 65; checks the maximum-length path.
- 0xFFFFFFFF / 0x80000001 -> Q=1, R=0x7FFFFFFE; the final compare has R' bit 31 set, proving the MSB-flipped unsigned compare.
- 1234 / 0 -> Q=0xFFFFFFFF, R=1234. With the macro: `div_by_zero`=1, latency 1, and ALU sees op 010 with operands 0,0. Without: flag 0, latency 64.
- Hold `res_ready`=0 for 5 cycles after 50 / 5 -> Q=10, R=0 stable throughout; `start_ready`=0; a concurrent `start_valid` with 9 / 3 is not accepted until after the handshake.
- Assert `resetn`=0 at cycle 10 of 0xFFFF0000 / 3 -> all outputs return to reset values asynchronously. A new request 9 / 3 then returns Q=3, R=0.
